status_register_stack: RTL and testbench

- Parametrised next-generation CPU status (flag) register.
- Adds the following over a fixed 8-bit P register:
  - N selectable write sources.
  - Per-bit write enables.
  - Configurable forced-1 and forced-0 bits.
  - A shadow save/restore stack used on interrupt entry and return.
- Sits in the CPU datapath between the controller / memory read path and the ALU flag inputs.
- All architectural updates are qualified by cpu_en.

---
 rtl/status_register_stack.sv | 146 ++++++++++++++
 tb/tb_status_register_stack.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/status_register_stack.sv
// Parametrised CPU status register with per-bit writes, forced bits and a shadow save/restore stack.
// Optional feature: define STATUS_REGISTER_STACK_DELAYED_WRITE_EN for one-step lag on DELAY_MASK bits.
module status_register_stack #(
    parameter int              WIDTH       = 8,
    parameter int              NUM_SRC     = 2,
    parameter int              DEPTH       = 4,
    parameter logic [WIDTH-1:0] RESET_VAL   = 8'h34,
    parameter logic [WIDTH-1:0] FORCE1_MASK = 8'h20,
    parameter logic [WIDTH-1:0] FORCE0_MASK = 8'h00,
    parameter logic [WIDTH-1:0] DELAY_MASK  = 8'h04,
    localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int DW    = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cpu_en,
    input  logic [NUM_SRC*WIDTH-1:0] wd,
    input  logic [SEL_W-1:0]         src_sel,
    input  logic [WIDTH-1:0]         p_write,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear_err,
    output logic [WIDTH-1:0]         p_out,
    output logic [DW-1:0]            depth,
    output logic                     overflow,
    output logic                     underflow
);

    // FORCE1 wins on overlap, so only the non-overlapping part of FORCE0 clears bits.
    localparam logic [WIDTH-1:0] CLR_MASK = FORCE0_MASK & ~FORCE1_MASK;

    function automatic logic [WIDTH-1:0] apply_force(input logic [WIDTH-1:0] x);
        return (x | FORCE1_MASK) & ~CLR_MASK;
    endfunction

    logic [WIDTH-1:0] p_reg, p_next;
    logic [DW-1:0]    depth_reg, depth_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;
    logic [WIDTH-1:0] stack_mem [DEPTH];

    logic [WIDTH-1:0] src_data [NUM_SRC];
    logic [WIDTH-1:0] wd_sel, base_val, write_imm, written_val, stack_top;
    logic             empty, full, pop_ok, exch, push_ok, ov_set, un_set;
    logic [AW-1:0]    top_idx, wr_idx;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign src_data[gi] = wd[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef STATUS_REGISTER_STACK_DELAYED_WRITE_EN
    logic [WIDTH-1:0] pend_val_reg, pend_val_next;
    logic [WIDTH-1:0] pend_mask_reg, pend_mask_next;
    // Pending bits land first; this cycle's immediate writes are layered on top.
    assign base_val  = (p_reg & ~pend_mask_reg) | (pend_val_reg & pend_mask_reg);
    assign write_imm = p_write & ~DELAY_MASK;
`else
    localparam logic [WIDTH-1:0] DELAY_OFF = DELAY_MASK & {WIDTH{1'b0}};
    assign base_val  = p_reg;
    assign write_imm = p_write & ~DELAY_OFF;
`endif

    assign empty     = (depth_reg == '0);
    assign full      = (depth_reg == DW'(DEPTH));
    assign pop_ok    = pop & ~empty;
    assign exch      = push & pop_ok;
    assign push_ok   = push & ~pop_ok & ~full;
    assign ov_set    = push & ~pop & full;
    assign un_set    = pop & empty;
    assign top_idx   = AW'(depth_reg - 1'b1);
    assign wr_idx    = exch ? top_idx : AW'(depth_reg);
    assign stack_top = stack_mem[top_idx];

    always_comb begin
        wd_sel = src_data[0];
        if (int'(src_sel) < NUM_SRC) begin
            wd_sel = src_data[src_sel];
        end
    end

    assign written_val = (base_val & ~write_imm) | (wd_sel & write_imm);

    always_comb begin
        p_next         = p_reg;
        depth_next     = depth_reg;
        overflow_next  = overflow_reg;
        underflow_next = underflow_reg;
`ifdef STATUS_REGISTER_STACK_DELAYED_WRITE_EN
        pend_val_next  = pend_val_reg;
        pend_mask_next = pend_mask_reg;
`endif
        if (cpu_en) begin
            p_next         = pop_ok ? apply_force(stack_top) : apply_force(written_val);
            overflow_next  = ov_set | (overflow_reg & ~clear_err);
            underflow_next = un_set | (underflow_reg & ~clear_err);
            if (push_ok) begin
                depth_next = depth_reg + 1'b1;
            end else if (pop_ok && !exch) begin
                depth_next = depth_reg - 1'b1;
            end
`ifdef STATUS_REGISTER_STACK_DELAYED_WRITE_EN
            pend_val_next  = wd_sel;
            pend_mask_next = pop_ok ? '0 : (p_write & DELAY_MASK);
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_reg         <= apply_force(RESET_VAL);
            depth_reg     <= '0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
`ifdef STATUS_REGISTER_STACK_DELAYED_WRITE_EN
            pend_val_reg  <= '0;
            pend_mask_reg <= '0;
`endif
        end else begin
            p_reg         <= p_next;
            depth_reg     <= depth_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
`ifdef STATUS_REGISTER_STACK_DELAYED_WRITE_EN
            pend_val_reg  <= pend_val_next;
            pend_mask_reg <= pend_mask_next;
`endif
        end
    end

    // Stack contents are undefined after reset, so the array stays free of reset logic.
    always_ff @(posedge clk) begin
        if (cpu_en && (push_ok || exch)) begin
            stack_mem[wr_idx] <= p_reg;
        end
    end

    assign p_out     = p_reg;
    assign depth     = depth_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: tb/tb_status_register_stack.sv
// Directed bench for status_register_stack: expected results queued per step, compared after each edge.
module tb_status_register_stack;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_en;
    logic [15:0] wd;
    logic [0:0]  src_sel;
    logic [7:0]  p_write;
    logic        push, pop, clear_err;
    logic [7:0]  p_out;
    logic [2:0]  depth;
    logic        overflow, underflow;

    typedef struct {
        logic [7:0] p;
        logic [2:0] d;
        logic       ov;
        logic       un;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    status_register_stack dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_en    (cpu_en),
        .wd        (wd),
        .src_sel   (src_sel),
        .p_write   (p_write),
        .push      (push),
        .pop       (pop),
        .clear_err (clear_err),
        .p_out     (p_out),
        .depth     (depth),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic expect_state(input string tag, input logic [7:0] ep, input logic [2:0] ed,
                                input logic eov, input logic eun);
        sb.push_back('{p: ep, d: ed, ov: eov, un: eun, tag: tag});
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL scoreboard_empty got %0d entries want >0", sb.size());
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks += 3;
            assert (p_out === e.p) else begin
                errors++;
                $error("FAIL %s p_out got %h want %h", e.tag, p_out, e.p);
            end
            assert (depth === e.d) else begin
                errors++;
                $error("FAIL %s depth got %0d want %0d", e.tag, depth, e.d);
            end
            assert (overflow === e.ov) else begin
                errors++;
                $error("FAIL %s overflow got %b want %b", e.tag, overflow, e.ov);
            end
            assert (underflow === e.un) else begin
                errors++;
                $error("FAIL %s underflow got %b want %b", e.tag, underflow, e.un);
            end
            $display("step %-12s p_out=%h depth=%0d ovf=%b unf=%b", e.tag, p_out, depth, overflow, underflow);
        end
    endtask

    // One cpu cycle: drive, queue the expectation, clock, then compare 1 time unit after the edge.
    task automatic cycle(input string tag, input logic en, input logic [7:0] w0, input logic [7:0] w1,
                         input logic sel, input logic [7:0] pw, input logic ps, input logic pp,
                         input logic clr, input logic [7:0] ep, input logic [2:0] ed,
                         input logic eov, input logic eun);
        cpu_en    = en;
        wd        = {w1, w0};
        src_sel   = sel;
        p_write   = pw;
        push      = ps;
        pop       = pp;
        clear_err = clr;
        expect_state(tag, ep, ed, eov, eun);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        reset = 1'b1; cpu_en = 1'b0; wd = '0; src_sel = '0; p_write = '0;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_state("reset", 8'h34, 3'd0, 1'b0, 1'b0);
        check_out();
        reset = 1'b0;

`ifdef STATUS_REGISTER_STACK_DELAYED_WRITE_EN
        //          tag           en   w0     w1     sel pw     ps   pp   clr  p      d     ov   un
        cycle("dly_clr_b2",  1'b1, 8'h00, 8'h00, 0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h34, 3'd0, 1'b0, 1'b0);
        cycle("dly_en_low",  1'b0, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h34, 3'd0, 1'b0, 1'b0);
        cycle("dly_land0",   1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h30, 3'd0, 1'b0, 1'b0);
        cycle("dly_set_b2",  1'b1, 8'h04, 8'h00, 0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h30, 3'd0, 1'b0, 1'b0);
        cycle("dly_land1",   1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h34, 3'd0, 1'b0, 1'b0);
        cycle("dly_push",    1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h34, 3'd1, 1'b0, 1'b0);
        cycle("dly_pend",    1'b1, 8'h00, 8'h00, 0, 8'h04, 1'b0, 1'b0, 1'b0, 8'h34, 3'd1, 1'b0, 1'b0);
        cycle("dly_pop",     1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h34, 3'd0, 1'b0, 1'b0);
        cycle("dly_cancel",  1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h34, 3'd0, 1'b0, 1'b0);
`else
        //          tag           en   w0     w1     sel pw     ps   pp   clr  p      d     ov   un
        cycle("src1_write",  1'b1, 8'h00, 8'hFF, 1, 8'hC3, 1'b0, 1'b0, 1'b0, 8'hF7, 3'd0, 1'b0, 1'b0);
        cycle("en_low",      1'b0, 8'h00, 8'h00, 1, 8'hFF, 1'b1, 1'b0, 1'b0, 8'hF7, 3'd0, 1'b0, 1'b0);
        cycle("force1",      1'b1, 8'h00, 8'h00, 1, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h20, 3'd0, 1'b0, 1'b0);
        cycle("w21",         1'b1, 8'h21, 8'h00, 0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h21, 3'd0, 1'b0, 1'b0);
        cycle("push1",       1'b1, 8'h22, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h22, 3'd1, 1'b0, 1'b0);
        cycle("push2",       1'b1, 8'h24, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h24, 3'd2, 1'b0, 1'b0);
        cycle("push3",       1'b1, 8'h28, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h28, 3'd3, 1'b0, 1'b0);
        cycle("push4",       1'b1, 8'h30, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h30, 3'd4, 1'b0, 1'b0);
        cycle("push_full",   1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h30, 3'd4, 1'b1, 1'b0);
        cycle("pop1_wr",     1'b1, 8'hFF, 8'hFF, 0, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h28, 3'd3, 1'b1, 1'b0);
        cycle("pop2",        1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h24, 3'd2, 1'b1, 1'b0);
        cycle("pop3",        1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h22, 3'd1, 1'b1, 1'b0);
        cycle("pop4",        1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 3'd0, 1'b1, 1'b0);
        cycle("pop_empty",   1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 3'd0, 1'b1, 1'b1);
        cycle("clear_err",   1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h21, 3'd0, 1'b0, 1'b0);
        cycle("wA0",         1'b1, 8'hA0, 8'h00, 0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'hA0, 3'd0, 1'b0, 1'b0);
        cycle("push_A0",     1'b1, 8'h21, 8'h00, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h21, 3'd1, 1'b0, 1'b0);
        cycle("exchange",    1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b1, 1'b0, 8'hA0, 3'd1, 1'b0, 1'b0);
        cycle("pop_exch",    1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 3'd0, 1'b0, 1'b0);
        cycle("pp_empty",    1'b1, 8'h44, 8'h00, 0, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h64, 3'd1, 1'b0, 1'b1);
        cycle("pop_pp",      1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h21, 3'd0, 1'b0, 1'b1);
        cycle("clr_vs_err",  1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h21, 3'd0, 1'b0, 1'b1);
        cycle("clear_err2",  1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h21, 3'd0, 1'b0, 1'b0);
        cycle("push_pre_rst",1'b1, 8'h00, 8'h00, 0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h21, 3'd1, 1'b0, 1'b0);

        // Reset asserted between edges must take effect without waiting for a clock.
        #2;
        reset = 1'b1;
        #1;
        expect_state("async_rst", 8'h34, 3'd0, 1'b0, 1'b0);
        check_out();
        cycle("rst_held",    1'b1, 8'hFF, 8'hFF, 0, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h34, 3'd0, 1'b0, 1'b0);
        reset = 1'b0;
        cycle("post_rst",    1'b1, 8'h0F, 8'h00, 0, 8'h0F, 1'b0, 1'b0, 1'b0, 8'h3F, 3'd0, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
